// File: rtl/spike_event_encoder.sv
// Hysteresis spike detector with ISI measurement, FWFT event FIFO and windowed spike-rate counter.
// Define SPIKE_TIMESTAMP_EN to attach a 16-bit sample timestamp to every queued event.
module spike_event_encoder #(
  parameter int ISI_W      = 16,
  parameter int WIN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             v_valid,
  input  logic [7:0]       v_in,
  input  logic [7:0]       thr_hi,
  input  logic [7:0]       thr_lo,
  input  logic [WIN_W-1:0] win_len,
  output logic             spike,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ISI_W-1:0] evt_isi,
  output logic             evt_first,
  output logic             evt_sat,
  output logic [15:0]      evt_ts,
  output logic [7:0]       rate_count,
  output logic             rate_valid,
  output logic [7:0]       drop_count
);

  typedef enum logic {BELOW, ABOVE} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
`ifdef SPIKE_TIMESTAMP_EN
  localparam int TS_W = 16;
`else
  localparam int TS_W = 0;
`endif
  localparam int ENT_W = ISI_W + 2 + TS_W;
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;
  localparam logic [PW:0]      FULL_CNT = (PW+1)'(FIFO_DEPTH);

  state_t           state;
  logic             first;
  logic [ISI_W-1:0] cnt;
  logic [ISI_W:0]   cnt_inc;
  logic             accept, is_spike, isi_sat;
  logic [ISI_W-1:0] isi_val, ev_isi;
  logic             ev_sat;
  logic [ENT_W-1:0] wr_entry, rd_entry;

  assign accept   = v_valid && ena;
  assign is_spike = accept && (state == BELOW) && ($signed(v_in) > $signed(thr_hi));
  assign cnt_inc  = (ISI_W+1)'(cnt) + (ISI_W+1)'(1);
  assign isi_sat  = (cnt_inc >= {1'b0, ISI_MAX});
  assign isi_val  = isi_sat ? ISI_MAX : cnt_inc[ISI_W-1:0];
  // The first spike after reset has no predecessor, so its interval is reported as zero.
  assign ev_isi   = first ? '0 : isi_val;
  assign ev_sat   = first ? 1'b0 : isi_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BELOW;
      first <= 1'b1;
      cnt   <= '0;
      spike <= 1'b0;
    end else begin
      spike <= is_spike;
      if (accept) begin
        if (is_spike) begin
          state <= ABOVE;
          first <= 1'b0;
          cnt   <= '0;
        end else begin
          if ((state == ABOVE) && ($signed(v_in) < $signed(thr_lo)))
            state <= BELOW;
          cnt <= isi_val;
        end
      end
    end
  end

`ifdef SPIKE_TIMESTAMP_EN
  logic [15:0] ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ts <= '0;
    else if (accept)
      ts <= ts + 16'd1;
  end

  assign wr_entry = {ts, ev_sat, first, ev_isi};
  assign evt_ts   = rd_entry[ENT_W-1 -: 16];
`else
  assign wr_entry = {ev_sat, first, ev_isi};
  assign evt_ts   = 16'h0000;
`endif

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [PW:0]      count;
  logic             full, pop, push;

  assign evt_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = evt_valid && evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the new event.
  assign push      = is_spike && (!full || pop);
  assign rd_entry  = mem[rptr];
  assign evt_isi   = rd_entry[ISI_W-1:0];
  assign evt_first = rd_entry[ISI_W];
  assign evt_sat   = rd_entry[ISI_W+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_entry;
        wptr      <= wptr + PW'(1);
      end
      if (pop)
        rptr <= rptr + PW'(1);
      if (push && !pop)
        count <= count + (PW+1)'(1);
      else if (pop && !push)
        count <= count - (PW+1)'(1);
      if (is_spike && !push && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end

  logic [WIN_W-1:0] wcnt;
  logic [7:0]       acc, acc_next;

  assign acc_next = (is_spike && (acc != 8'hFF)) ? acc + 8'd1 : acc;

  // Using >= lets a shortened win_len close an overrun window on the next sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt       <= '0;
      acc        <= '0;
      rate_count <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (win_len == '0) begin
        wcnt <= '0;
        acc  <= '0;
      end else if (accept) begin
        if (wcnt >= win_len - WIN_W'(1)) begin
          rate_count <= acc_next;
          rate_valid <= 1'b1;
          wcnt       <= '0;
          acc        <= '0;
        end else begin
          wcnt <= wcnt + WIN_W'(1);
          acc  <= acc_next;
        end
      end
    end
  end

endmodule
